// File: rtl/gcd_arb_pkg.sv
// Shared types and helpers for the gcd request arbiter: FSM state encoding,
// default datapath width and packed-slice indexing.
package gcd_arb_pkg;

  localparam int GCD_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } arb_state_t;

  // Low bit of slice idx inside a packed vector of width-wide fields
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request found
// searching upward from rr_ptr with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!any_grant && req[idx]) begin
          any_grant      = 1'b1;
          grant[idx]     = 1'b1;
          grant_idx      = idx;
        end
      end
    end
  end

endmodule

// File: rtl/gcd_req_arbiter.sv
// Shares one ap_ctrl_hs gcd core between NUM_REQ requesters with round-robin
// arbitration. Optional macro GCD_ARB_ZERO_BYPASS_EN answers zero-operand requests locally.
module gcd_req_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = GCD_DATA_W
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         core_a,
  output logic [DATA_W-1:0]         core_b,
  output logic                      core_start,
  input  logic                      core_idle,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_return,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [DATA_W-1:0] core_a_d, core_b_d, rsp_data_d;
  logic [DATA_W-1:0] win_a, win_b;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;
  logic               arb_en;

  // Reset gating keeps req_ready low while ap_rst_n is asserted
  assign arb_en = ap_rst_n && (state_q == S_IDLE) && core_idle;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign win_a = req_a[slice_lo(int'(grant_idx), DATA_W) +: DATA_W];
  assign win_b = req_b[slice_lo(int'(grant_idx), DATA_W) +: DATA_W];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    core_a_d   = core_a;
    core_b_d   = core_b;
    rsp_data_d = rsp_data;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (any_grant) begin
          req_ready = grant;
          owner_d   = grant_idx;
          core_a_d  = win_a;
          core_b_d  = win_b;
`ifdef GCD_ARB_ZERO_BYPASS_EN
          if ((win_a == '0) || (win_b == '0)) begin
            rsp_data_d = win_a | win_b;
            state_d    = S_RESP;
          end else begin
            state_d = S_RUN;
          end
`else
          state_d = S_RUN;
`endif
        end
      end

      // ap_ctrl_hs: start stays high through the done cycle inclusive
      S_RUN: begin
        core_start = 1'b1;
        if (core_done) begin
          rsp_data_d = core_return;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      core_a   <= '0;
      core_b   <= '0;
      rsp_data <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      core_a   <= core_a_d;
      core_b   <= core_b_d;
      rsp_data <= rsp_data_d;
    end
  end

endmodule
